// File: rtl/reset_sequencer_if.sv
// Request/grant and per-domain reset bundle between reset requesters and reset_sequencer.
// Member prefixes are from the sequencer's point of view; master is the requester side.
interface reset_sequencer_if #(
  parameter int NREQ = 4,
  parameter int NDOM = 3
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] i_req;
  logic [NREQ-1:0] o_grant;
  logic [NDOM-1:0] o_out_rst;
  logic            o_busy;
  logic            o_done;
  logic [SW-1:0]   o_last_src;

  modport master (
    output i_req,
    input  o_grant,
    input  o_out_rst,
    input  o_busy,
    input  o_done,
    input  o_last_src
  );

  modport slave (
    input  i_req,
    output o_grant,
    output o_out_rst,
    output o_busy,
    output o_done,
    output o_last_src
  );
endinterface

// File: rtl/reset_sequencer.sv
// Round-robin soft-reset arbiter: holds all domains in reset for HOLD cycles, then releases them GAP apart.
// Optional macro RSTSEQ_RESTART_EN lets a request seen mid-sequence abort it and start a new one.
module reset_sequencer #(
  parameter int NREQ = 4,
  parameter int NDOM = 3,
  parameter int HOLD = 16,
  parameter int GAP  = 4
) (
  input logic              clk,
  input logic              rst,
  reset_sequencer_if.slave io_seq
);

  localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW   = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

`ifdef RSTSEQ_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0]   GAP_LAST  = CW'(GAP - 1);
  localparam logic [DW-1:0]   DOM_LAST  = DW'(NDOM - 1);
  localparam logic [SW-1:0]   REQ_LAST  = SW'(NREQ - 1);
  localparam logic [NDOM-1:0] ALL_DOM   = {NDOM{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_next_cnt;
  logic [DW-1:0]   r_idx;
  logic [DW-1:0]   w_next_idx;
  logic [SW-1:0]   r_ptr;
  logic [SW-1:0]   w_next_ptr;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] w_next_grant;
  logic [SW-1:0]   r_last_src;
  logic [SW-1:0]   w_next_last_src;
  logic [NDOM-1:0] r_out_rst;
  logic [NDOM-1:0] w_next_out_rst;
  logic            r_done;
  logic            w_next_done;

  logic            w_any_req;
  logic            w_accept;
  logic [SW-1:0]   w_arb_idx;
  logic [SW-1:0]   w_arb_next;
  logic [NDOM-1:0] w_dom_bit;

  // First requester at or after the pointer, scanning forward and wrapping.
  function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [SW-1:0]   ptr);
    int j;
    rr_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) rr_pick = SW'(j);
    end
  endfunction

  always_comb begin
    w_any_req  = |io_seq.i_req;
    w_accept   = w_any_req && ((r_state == IDLE) || RESTART);
    w_arb_idx  = rr_pick(io_seq.i_req, r_ptr);
    w_arb_next = (w_arb_idx == REQ_LAST) ? '0 : w_arb_idx + SW'(1);
    w_dom_bit  = NDOM'(1) << r_idx;
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    w_next_idx      = r_idx;
    w_next_ptr      = r_ptr;
    w_next_grant    = '0;
    w_next_last_src = r_last_src;
    w_next_out_rst  = r_out_rst;
    w_next_done     = 1'b0;

    if (w_accept) begin
      w_next_state    = ASSERT;
      w_next_cnt      = '0;
      w_next_idx      = '0;
      w_next_ptr      = w_arb_next;
      w_next_grant    = NREQ'(1) << w_arb_idx;
      w_next_last_src = w_arb_idx;
      w_next_out_rst  = ALL_DOM;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_out_rst = '0;
        end
        ASSERT: begin
          if (r_cnt == HOLD_LAST) begin
            w_next_out_rst = r_out_rst & ~NDOM'(1);
            w_next_cnt     = '0;
            if (NDOM == 1) begin
              w_next_state = IDLE;
              w_next_done  = 1'b1;
            end else begin
              w_next_state = RELEASE;
              w_next_idx   = DW'(1);
            end
          end else begin
            w_next_cnt = r_cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            w_next_out_rst = r_out_rst & ~w_dom_bit;
            w_next_cnt     = '0;
            if (r_idx == DOM_LAST) begin
              w_next_state = IDLE;
              w_next_done  = 1'b1;
            end else begin
              w_next_idx = r_idx + DW'(1);
            end
          end else begin
            w_next_cnt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // Reset parks the block in ASSERT so the power-on release runs with no request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ASSERT;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_last_src <= '0;
      r_out_rst  <= ALL_DOM;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_idx      <= w_next_idx;
      r_ptr      <= w_next_ptr;
      r_grant    <= w_next_grant;
      r_last_src <= w_next_last_src;
      r_out_rst  <= w_next_out_rst;
      r_done     <= w_next_done;
    end
  end

  assign io_seq.o_grant    = r_grant;
  assign io_seq.o_out_rst  = r_out_rst;
  assign io_seq.o_busy     = (r_state != IDLE);
  assign io_seq.o_done     = r_done;
  assign io_seq.o_last_src = r_last_src;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: an event-list model predicts grant/release/done edges into a queue
// that a monitor drains as the DUT shows them; a second instance covers HOLD=GAP=NDOM=1.
module tb_reset_sequencer;

  localparam int NREQ = 4;
  localparam int NDOM = 3;
  localparam int HOLD = 16;
  localparam int GAP  = 4;

`ifdef RSTSEQ_RESTART_EN
  localparam bit RESTART_MODEL = 1'b1;
`else
  localparam bit RESTART_MODEL = 1'b0;
`endif

  localparam int EV_GRANT = 0;
  localparam int EV_FALL  = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int kind;
    int cyc;
    int grant;
    int src;
    int outRst;
  } evt_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  int checks        = 0;
  int errors        = 0;
  int cyc           = 0;
  int rr            = 0;
  int modelDoneEdge = 0;
  int lastGrantEdge = 0;
  logic [NDOM-1:0] prevOutRst = '1;
  evt_t expQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  reset_sequencer_if #(.NREQ(NREQ), .NDOM(NDOM)) seqIf ();
  reset_sequencer_if #(.NREQ(NREQ), .NDOM(1))    seq2If ();

  reset_sequencer #(.NREQ(NREQ), .NDOM(NDOM), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_seq (seqIf.slave)
  );

  reset_sequencer #(.NREQ(NREQ), .NDOM(1), .HOLD(1), .GAP(1)) dutEdge (
    .clk    (clk),
    .rst    (rst2),
    .io_seq (seq2If.slave)
  );

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int modelPick(input logic [NREQ-1:0] pattern);
    int k;
    for (int o = 0; o < NREQ; o++) begin
      k = (rr + o) % NREQ;
      if (pattern[k]) return k;
    end
    return -1;
  endfunction

  // Everything one sequence starting at edge e will show, in observation order.
  task automatic pushSequence(input int e, input int src, input bit withGrant);
    evt_t ev;
    int allOnes;
    allOnes = (1 << NDOM) - 1;
    ev.grant  = 0;
    ev.src    = 0;
    if (withGrant) begin
      ev.kind   = EV_GRANT;
      ev.cyc    = e;
      ev.grant  = 1 << src;
      ev.src    = src;
      ev.outRst = allOnes;
      expQ.push_back(ev);
    end
    for (int d = 0; d < NDOM; d++) begin
      ev.kind   = EV_FALL;
      ev.cyc    = e + HOLD + d * GAP;
      ev.outRst = allOnes & ~((1 << (d + 1)) - 1);
      expQ.push_back(ev);
    end
    ev.kind   = EV_DONE;
    ev.cyc    = e + HOLD + (NDOM - 1) * GAP;
    ev.outRst = 0;
    expQ.push_back(ev);
    modelDoneEdge = ev.cyc;
    lastGrantEdge = e;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] pattern, input int holdCycles);
    int k;
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      seqIf.i_req = pattern;
      if (pattern != '0 && (cyc >= modelDoneEdge || RESTART_MODEL)) begin
        k  = modelPick(pattern);
        rr = (k + 1) % NREQ;
        while (expQ.size() > 0 && expQ[$].cyc > cyc) void'(expQ.pop_back());
        pushSequence(cyc + 1, k, 1'b1);
      end
    end
    @(negedge clk);
    seqIf.i_req = '0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic waitIdle();
    if (modelDoneEdge > cyc) waitCycles(modelDoneEdge - cyc);
  endtask

  task automatic scoreEvent(input int kind);
    evt_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpectedEvent", kind, -1);
      return;
    end
    e = expQ.pop_front();
    checkOutput("evtKind", kind, e.kind);
    checkOutput("evtCycle", cyc, e.cyc);
    case (e.kind)
      EV_GRANT: begin
        checkOutput("grantVec", int'(seqIf.o_grant), e.grant);
        checkOutput("lastSrc", int'(seqIf.o_last_src), e.src);
        checkOutput("grantOutRst", int'(seqIf.o_out_rst), e.outRst);
        checkOutput("grantBusy", int'(seqIf.o_busy), 1);
      end
      EV_FALL: checkOutput("fallOutRst", int'(seqIf.o_out_rst), e.outRst);
      default: checkOutput("doneBusy", int'(seqIf.o_busy), 0);
    endcase
  endtask

  // Monitor: any grant, OUT_RST change or DONE is an event to be matched against the queue.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (seqIf.o_grant != '0) scoreEvent(EV_GRANT);
      else if (seqIf.o_out_rst != prevOutRst) scoreEvent(EV_FALL);
      if (seqIf.o_done) scoreEvent(EV_DONE);
    end
    prevOutRst = seqIf.o_out_rst;
  end

  initial begin
    seqIf.i_req  = '0;
    seq2If.i_req = '0;

    repeat (3) @(negedge clk);
    checkOutput("rstOutRst", int'(seqIf.o_out_rst), 7);
    checkOutput("rstGrant", int'(seqIf.o_grant), 0);
    checkOutput("rstDone", int'(seqIf.o_done), 0);
    checkOutput("rstBusy", int'(seqIf.o_busy), 1);
    checkOutput("rstLastSrc", int'(seqIf.o_last_src), 0);
    rst = 1'b0;
    pushSequence(cyc, 0, 1'b0);

    waitIdle();
    waitCycles(3);
    checkOutput("idleBusy", int'(seqIf.o_busy), 0);
    applyStimulus(4'b0100, 1);

    waitIdle();
    waitCycles(2);
    applyStimulus(4'b1111, 4 * (HOLD + (NDOM - 1) * GAP + 1) + 1);

    waitIdle();
    waitCycles(2);
    applyStimulus(4'b0001, 1);
    waitCycles(4);
    applyStimulus(4'b0010, 1);

    waitIdle();
    waitCycles(2);
    applyStimulus(4'b1000, 1);
    waitCycles(lastGrantEdge + HOLD + GAP + 1 - cyc);
    checkOutput("midSeqOutRst", int'(seqIf.o_out_rst), 4);
    #1 rst = 1'b1;
    #1;
    checkOutput("asyncOutRst", int'(seqIf.o_out_rst), 7);
    checkOutput("asyncGrant", int'(seqIf.o_grant), 0);
    checkOutput("asyncLastSrc", int'(seqIf.o_last_src), 0);
    checkOutput("asyncBusy", int'(seqIf.o_busy), 1);
    expQ.delete();
    rr = 0;
    waitCycles(2);
    rst = 1'b0;
    pushSequence(cyc, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      waitCycles($urandom_range(0, 30));
      applyStimulus(NREQ'($urandom_range(0, (1 << NREQ) - 1)), $urandom_range(1, 2));
    end

    waitIdle();
    waitCycles(3);
    checkOutput("queueDrained", expQ.size(), 0);

    @(negedge clk);
    checkOutput("edgeRstOutRst", int'(seq2If.o_out_rst), 1);
    checkOutput("edgeRstBusy", int'(seq2If.o_busy), 1);
    rst2 = 1'b0;
    @(posedge clk) #1;
    checkOutput("edgePonOutRst", int'(seq2If.o_out_rst), 0);
    checkOutput("edgePonDone", int'(seq2If.o_done), 1);
    checkOutput("edgePonBusy", int'(seq2If.o_busy), 0);
    @(negedge clk) seq2If.i_req = 4'b0010;
    @(posedge clk) #1;
    checkOutput("edgeGrant", int'(seq2If.o_grant), 2);
    checkOutput("edgeLastSrc", int'(seq2If.o_last_src), 1);
    checkOutput("edgeGrantOutRst", int'(seq2If.o_out_rst), 1);
    checkOutput("edgeGrantDone", int'(seq2If.o_done), 0);
    @(negedge clk) seq2If.i_req = '0;
    @(posedge clk) #1;
    checkOutput("edgeRelOutRst", int'(seq2If.o_out_rst), 0);
    checkOutput("edgeRelDone", int'(seq2If.o_done), 1);
    checkOutput("edgeRelBusy", int'(seq2If.o_busy), 0);
    checkOutput("edgeRelGrant", int'(seq2If.o_grant), 0);
    @(negedge clk) seq2If.i_req = 4'b0001;
    @(posedge clk) #1;
    checkOutput("edgeBackGrant", int'(seq2If.o_grant), 1);
    checkOutput("edgeBackLastSrc", int'(seq2If.o_last_src), 0);
    checkOutput("edgeBackOutRst", int'(seq2If.o_out_rst), 1);
    @(negedge clk) seq2If.i_req = '0;
    @(posedge clk) #1;
    checkOutput("edgeBackDone", int'(seq2If.o_done), 1);
    @(posedge clk) #1;
    checkOutput("edgeIdleGrant", int'(seq2If.o_grant), 0);
    checkOutput("edgeIdleDone", int'(seq2If.o_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
